video_dither_gen: RTL and testbench



---
 rtl/video_dither_gen_if.sv | 32 +++
 rtl/video_dither_gen.sv | 214 +++++++++++++++++++++
 tb/tb_video_dither_gen.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/video_dither_gen_if.sv
// Pixel-side bundle for video_dither_gen: mode request, sync/enable and RGB in,
// delayed sync/enable and reduced-depth RGB out.
interface video_dither_gen_if #(
    parameter int unsigned INBITS  = 8,
    parameter int unsigned OUTBITS = 4
);
    logic [1:0]         mode;
    logic               hsync;
    logic               vsync;
    logic               vid_ena;
    logic [INBITS-1:0]  iRed;
    logic [INBITS-1:0]  iGreen;
    logic [INBITS-1:0]  iBlue;
    logic               oHsync;
    logic               oVsync;
    logic               oVid_ena;
    logic [OUTBITS-1:0] oRed;
    logic [OUTBITS-1:0] oGreen;
    logic [OUTBITS-1:0] oBlue;

    // Video generator side: drives pixels, observes dithered result
    modport master (
        output mode, hsync, vsync, vid_ena, iRed, iGreen, iBlue,
        input  oHsync, oVsync, oVid_ena, oRed, oGreen, oBlue
    );

    // Dither stage side
    modport slave (
        input  mode, hsync, vsync, vid_ena, iRed, iGreen, iBlue,
        output oHsync, oVsync, oVid_ena, oRed, oGreen, oBlue
    );
endinterface

// File: rtl/video_dither_gen.sv
// video_dither_gen: reduces INBITS-per-channel RGB to OUTBITS-per-channel with
// run-time selectable truncate / 4x4 ordered / spatio-temporal ordered / LFSR
// noise dithering. Fixed two-clock latency for pixels, syncs and vid_ena.
// Optional feature macro DITHER_LFSR_EN: when defined, mode 3 adds LFSR noise;
// when undefined no LFSR is built and mode 3 behaves as mode 2.
module video_dither_gen #(
    parameter int unsigned INBITS    = 8,
    parameter int unsigned OUTBITS   = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset_in,
    video_dither_gen_if.slave vif
);

    localparam int unsigned D   = INBITS - OUTBITS;
    localparam int unsigned TW  = (D > 0) ? D : 1;
    localparam int unsigned SW  = TW + 4;
    localparam int unsigned SHL = (D >= 4) ? D - 4 : 0;
    localparam int unsigned SHR = (D >= 4) ? 0 : 4 - D;

    // Elaboration-time sanity checks on the configuration
    if (INBITS < OUTBITS) begin : g_bad_width
        $error("video_dither_gen: INBITS must be >= OUTBITS");
    end
    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
        $error("video_dither_gen: LFSR_SEED must be nonzero");
    end

    // 4x4 Bayer matrix, row-major
    function automatic logic [3:0] bayer(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] v;
        case ({row, col})
            4'd0:    v = 4'd0;
            4'd1:    v = 4'd8;
            4'd2:    v = 4'd2;
            4'd3:    v = 4'd10;
            4'd4:    v = 4'd12;
            4'd5:    v = 4'd4;
            4'd6:    v = 4'd14;
            4'd7:    v = 4'd6;
            4'd8:    v = 4'd3;
            4'd9:    v = 4'd11;
            4'd10:   v = 4'd1;
            4'd11:   v = 4'd9;
            4'd12:   v = 4'd15;
            4'd13:   v = 4'd7;
            4'd14:   v = 4'd13;
            default: v = 4'd5;
        endcase
        return v;
    endfunction

    // Stage-1 registers (these also serve as previous-cycle sync/enable for edge detect)
    logic               hs1_q, vs1_q, ven1_q;
    logic [INBITS-1:0]  red1_q, grn1_q, blu1_q;
    logic [TW-1:0]      t1_q, t_d;

    // Raster counters and latched mode
    logic [1:0]         x_q, x_d;
    logic [1:0]         y_q, y_d;
    logic [1:0]         frame_q, frame_d;
    logic [1:0]         mode_q, mode_d;
    logic               vs_rise, ven_fall;

    // Stage-2 (output) registers
    logic               hs2_q, vs2_q, ven2_q;
    logic [OUTBITS-1:0] red2_q, grn2_q, blu2_q;
    logic [OUTBITS-1:0] red_d, grn_d, blu_d;

    // Bayer lookup path
    logic               stagger;
    logic [1:0]         bx, by;
    logic [3:0]         bval;

`ifdef DITHER_LFSR_EN
    logic [15:0]        lfsr_q, lfsr_d;

    // Noise LFSR, taps x^16+x^14+x^13+x^11, steps only during active video
    always_comb begin
        lfsr_d = lfsr_q;
        if (vif.vid_ena) begin
            lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        end
    end

    // LFSR state register
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`endif

    // Counter / mode-latch next state; vsync rise beats a same-cycle vid_ena fall
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        frame_d  = frame_q;
        mode_d   = mode_q;
        vs_rise  = vif.vsync & ~vs1_q;
        ven_fall = ven1_q & ~vif.vid_ena;
        x_d      = vif.vid_ena ? x_q + 2'd1 : 2'd0;
        if (vs_rise) begin
            y_d     = 2'd0;
            frame_d = frame_q + 2'd1;
            mode_d  = vif.mode;
        end else if (ven_fall) begin
            y_d = y_q + 2'd1;
        end
    end

    // Threshold for the current pixel, shared by all three channels
    always_comb begin
        t_d     = '0;
        stagger = (mode_q == 2'd2);
`ifndef DITHER_LFSR_EN
        stagger = stagger | (mode_q == 2'd3);
`endif
        bx   = x_q + (stagger ? {frame_q[0], 1'b0} : 2'b00);
        by   = y_q + (stagger ? {frame_q[1], 1'b0} : 2'b00);
        bval = bayer(by, bx);
        if (mode_q != 2'd0) begin
            t_d = TW'((SW'(bval) << SHL) >> SHR);
        end
`ifdef DITHER_LFSR_EN
        if (mode_q == 2'd3) begin
            t_d = TW'(lfsr_q);
        end
`endif
    end

    // Stage 1: capture inputs, threshold and counters
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            hs1_q   <= 1'b0;
            vs1_q   <= 1'b0;
            ven1_q  <= 1'b0;
            red1_q  <= '0;
            grn1_q  <= '0;
            blu1_q  <= '0;
            t1_q    <= '0;
            x_q     <= 2'd0;
            y_q     <= 2'd0;
            frame_q <= 2'd0;
            mode_q  <= 2'd0;
        end else begin
            hs1_q   <= vif.hsync;
            vs1_q   <= vif.vsync;
            ven1_q  <= vif.vid_ena;
            red1_q  <= vif.iRed;
            grn1_q  <= vif.iGreen;
            blu1_q  <= vif.iBlue;
            t1_q    <= t_d;
            x_q     <= x_d;
            y_q     <= y_d;
            frame_q <= frame_d;
            mode_q  <= mode_d;
        end
    end

    if (D == 0) begin : g_pass
        // No bits to drop: data passes straight through
        always_comb begin
            red_d = OUTBITS'(red1_q);
            grn_d = OUTBITS'(grn1_q);
            blu_d = OUTBITS'(blu1_q);
        end
    end else begin : g_dith
        // Add threshold one bit wider than the pixel, saturate on carry, keep MSBs
        function automatic logic [OUTBITS-1:0] add_sat(input logic [INBITS-1:0] px,
                                                       input logic [TW-1:0]     t);
            logic [INBITS:0] s;
            s = {1'b0, px} + (INBITS+1)'(t);
            return s[INBITS] ? {OUTBITS{1'b1}} : s[INBITS-1:D];
        endfunction

        // Per-channel dither with the shared threshold
        always_comb begin
            red_d = add_sat(red1_q, t1_q);
            grn_d = add_sat(grn1_q, t1_q);
            blu_d = add_sat(blu1_q, t1_q);
        end
    end

    // Stage 2: register outputs, blank pixels outside active video
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            hs2_q  <= 1'b0;
            vs2_q  <= 1'b0;
            ven2_q <= 1'b0;
            red2_q <= '0;
            grn2_q <= '0;
            blu2_q <= '0;
        end else begin
            hs2_q  <= hs1_q;
            vs2_q  <= vs1_q;
            ven2_q <= ven1_q;
            red2_q <= ven1_q ? red_d : '0;
            grn2_q <= ven1_q ? grn_d : '0;
            blu2_q <= ven1_q ? blu_d : '0;
        end
    end

    assign vif.oHsync   = hs2_q;
    assign vif.oVsync   = vs2_q;
    assign vif.oVid_ena = ven2_q;
    assign vif.oRed     = red2_q;
    assign vif.oGreen   = grn2_q;
    assign vif.oBlue    = blu2_q;

endmodule

// File: tb/tb_video_dither_gen.sv
// Directed bench for video_dither_gen with a scoreboard: each driven pixel
// pushes its expected output, popped two clocks later at the falling edge.
module tb_video_dither_gen;

    localparam int unsigned INB  = 8;
    localparam int unsigned OUTB = 4;

    logic clk = 1'b0;
    logic reset_in;

    always #5 clk = ~clk;

    video_dither_gen_if #(.INBITS(INB), .OUTBITS(OUTB)) vif ();

    video_dither_gen #(
        .INBITS   (INB),
        .OUTBITS  (OUTB),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clk     (clk),
        .reset_in(reset_in),
        .vif     (vif)
    );

    int checks = 0;
    int errors = 0;

    logic [14:0] exp_q[$];
    string       tag_q[$];

    // Reference model state
    int          mx, my, mframe, mmode;
    logic        m_vs_prev, m_ven_prev;
    logic [1:0]  mode_req;
`ifdef DITHER_LFSR_EN
    logic [15:0] mlfsr;
`endif

    int bay[16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};

    function automatic int thresh();
        int bxi, byi;
        if (mmode == 0) return 0;
`ifdef DITHER_LFSR_EN
        if (mmode == 3) return int'(mlfsr) % 16;
`endif
        bxi = mx;
        byi = my;
        if (mmode >= 2) begin
            bxi = (mx + 2 * (mframe % 2)) % 4;
            byi = (my + 2 * (mframe / 2)) % 4;
        end
        return bay[byi * 4 + bxi];
    endfunction

    function automatic int dith(input int px, input int t);
        int s;
        s = px + t;
        if (s > 255) return 15;
        return s / 16;
    endfunction

    task automatic model_reset();
        mx = 0; my = 0; mframe = 0; mmode = 0;
        m_vs_prev = 1'b0; m_ven_prev = 1'b0;
`ifdef DITHER_LFSR_EN
        mlfsr = 16'hACE1;
`endif
    endtask

    // One pixel clock: check the oldest pending output, drive new inputs, update model
    task automatic step(input string tag, input logic hs, input logic vs, input logic ven,
                        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        logic [14:0] obs, e;
        logic [3:0]  er, eg, eb;
        string       tg;
        int          t;
        if (exp_q.size() >= 2) begin
            e   = exp_q.pop_front();
            tg  = tag_q.pop_front();
            obs = {vif.oHsync, vif.oVsync, vif.oVid_ena, vif.oRed, vif.oGreen, vif.oBlue};
            checks++;
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", tg, obs, e);
            end
        end
        vif.mode    = mode_req;
        vif.hsync   = hs;
        vif.vsync   = vs;
        vif.vid_ena = ven;
        vif.iRed    = r;
        vif.iGreen  = g;
        vif.iBlue   = b;
        t  = thresh();
        er = ven ? 4'(dith(int'(r), t)) : 4'h0;
        eg = ven ? 4'(dith(int'(g), t)) : 4'h0;
        eb = ven ? 4'(dith(int'(b), t)) : 4'h0;
        exp_q.push_back({hs, vs, ven, er, eg, eb});
        tag_q.push_back(tag);
        if (vs && !m_vs_prev) begin
            my     = 0;
            mframe = (mframe + 1) % 4;
            mmode  = int'(mode_req);
        end else if (m_ven_prev && !ven) begin
            my = (my + 1) % 4;
        end
        mx = ven ? (mx + 1) % 4 : 0;
`ifdef DITHER_LFSR_EN
        if (ven) mlfsr = {mlfsr[0] ^ mlfsr[2] ^ mlfsr[3] ^ mlfsr[5], mlfsr[15:1]};
`endif
        m_vs_prev  = vs;
        m_ven_prev = ven;
        @(negedge clk);
    endtask

    // Reset for one clock from a falling edge; outputs must clear asynchronously
    task automatic do_reset();
        logic [14:0] obs;
        reset_in    = 1'b1;
        vif.hsync   = 1'b0;
        vif.vsync   = 1'b0;
        vif.vid_ena = 1'b0;
        #1;
        obs = {vif.oHsync, vif.oVsync, vif.oVid_ena, vif.oRed, vif.oGreen, vif.oBlue};
        checks++;
        assert (obs === 15'h0) else begin
            errors++;
            $error("FAIL async_reset: observed %h expected %h", obs, 15'h0);
        end
        @(negedge clk);
        reset_in = 1'b0;
        exp_q.delete();
        tag_q.delete();
        repeat (2) begin
            exp_q.push_back(15'h0);
            tag_q.push_back("reset_state");
        end
        model_reset();
    endtask

    task automatic vpulse(input logic [1:0] m);
        mode_req = m;
        step("vsync", 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        step("vsync", 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        step("vsync", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic line(input string tag, input int n,
                        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        step("hblank", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        step("hblank", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        step("hblank", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 1'b1, r, g, b);
        step("hblank", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic frame4(input string tag, input logic [7:0] r,
                          input logic [7:0] g, input logic [7:0] b);
        for (int l = 0; l < 4; l++) line(tag, 4, r, g, b);
    endtask

    initial begin
        reset_in    = 1'b1;
        mode_req    = 2'd0;
        vif.mode    = 2'd0;
        vif.hsync   = 1'b0;
        vif.vsync   = 1'b0;
        vif.vid_ena = 1'b0;
        vif.iRed    = '0;
        vif.iGreen  = '0;
        vif.iBlue   = '0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Truncate mode, flat field
        vpulse(2'd0);
        line("trunc_flat", 8, 8'h5F, 8'h5F, 8'h5F);

        // Ordered dither and saturation
        vpulse(2'd1);
        frame4("ordered_ff", 8'h00, 8'h08, 8'hFF);
        vpulse(2'd1);
        frame4("ordered_f1", 8'h80, 8'h08, 8'hF1);

        // Spatio-temporal over four frames
        for (int f = 0; f < 4; f++) begin
            vpulse(2'd2);
            frame4("spatio_temporal", 8'h08, 8'h47, 8'hF8);
        end

        // Mode request mid-frame is ignored until the next vsync rise
        vpulse(2'd0);
        line("pre_mode_change", 4, 8'h08, 8'h08, 8'h08);
        mode_req = 2'd1;
        line("mid_frame_mode", 4, 8'h08, 8'h08, 8'h08);
        line("mid_frame_mode", 4, 8'h08, 8'h08, 8'h08);
        vpulse(2'd1);
        frame4("after_vsync_mode", 8'h08, 8'h08, 8'h08);

        // Simultaneous vid_ena fall and vsync rise
        step("edge_pair", 1'b0, 1'b0, 1'b1, 8'h08, 8'h08, 8'h08);
        step("edge_pair", 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        step("edge_pair", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        line("edge_pair_line", 4, 8'h08, 8'h08, 8'h08);

        // Mode 3 frame, reset mid-line, then the same frame again
        vpulse(2'd3);
        frame4("mode3_first", 8'h08, 8'h80, 8'hF8);
        step("mode3_partial", 1'b0, 1'b0, 1'b1, 8'h08, 8'h80, 8'hF8);
        step("mode3_partial", 1'b0, 1'b0, 1'b1, 8'h08, 8'h80, 8'hF8);
        do_reset();
        mode_req = 2'd3;
        vpulse(2'd3);
        frame4("mode3_replay", 8'h08, 8'h80, 8'hF8);

        // Drain the pipeline
        repeat (3) step("drain", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
